// File: rtl/red_pitaya_sys_pkg.sv
// Shared types for the red_pitaya system-bus initiator.
// FSM states, timeout counter width and response status flags.
package red_pitaya_sys_pkg;

  localparam int SYS_TMO_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic err;
    logic tmo;
  } rsp_stat_t;

endpackage

// File: rtl/red_pitaya_sys_master_if.sv
// Command/response handshake and system-bus signals of the initiator.
// master: the initiator side; slave: the sequencer/responder side.
interface red_pitaya_sys_master_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          cmd_valid_i;
  logic          cmd_ready_o;
  logic          cmd_wr_i;
  logic [AW-1:0] cmd_addr_i;
  logic [DW-1:0] cmd_wdata_i;
  logic          rsp_valid_o;
  logic          rsp_ready_i;
  logic [DW-1:0] rsp_rdata_o;
  logic          rsp_err_o;
  logic          rsp_tmo_o;
  logic [AW-1:0] sys_addr_o;
  logic [DW-1:0] sys_wdata_o;
  logic          sys_wen_o;
  logic          sys_ren_o;
  logic [DW-1:0] sys_rdata_i;
  logic          sys_err_i;
  logic          sys_ack_i;
  logic          busy_o;

  modport master (
    input  cmd_valid_i, cmd_wr_i, cmd_addr_i, cmd_wdata_i,
    input  rsp_ready_i, sys_rdata_i, sys_err_i, sys_ack_i,
    output cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    output rsp_tmo_o, sys_addr_o, sys_wdata_o, sys_wen_o,
    output sys_ren_o, busy_o
  );

  modport slave (
    output cmd_valid_i, cmd_wr_i, cmd_addr_i, cmd_wdata_i,
    output rsp_ready_i, sys_rdata_i, sys_err_i, sys_ack_i,
    input  cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    input  rsp_tmo_o, sys_addr_o, sys_wdata_o, sys_wen_o,
    input  sys_ren_o, busy_o
  );
endinterface

// File: rtl/red_pitaya_sys_tmo.sv
// Ack timeout counter: cleared by load, counts while en, flags expiry at TMO.
// Built only when SYS_MST_TIMEOUT_EN is defined.
module red_pitaya_sys_tmo
  import red_pitaya_sys_pkg::*;
#(
  parameter int TMO = 255
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic load,
  input  logic en,
  output logic expire
);

  logic [SYS_TMO_W-1:0] cnt;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expire = en && (cnt == SYS_TMO_W'(TMO));

endmodule

// File: rtl/red_pitaya_sys_master.sv
// System-bus initiator: one command in, one bus transfer, one response out.
// Optional ack timeout enabled by defining SYS_MST_TIMEOUT_EN.
module red_pitaya_sys_master
  import red_pitaya_sys_pkg::*;
#(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int TMO = 255
) (
  input logic clk_i,
  input logic rstn_i,
  red_pitaya_sys_master_if.master bus
);

  if (TMO < 1 || TMO > 65535) begin : g_bad_tmo
    $error("red_pitaya_sys_master: TMO out of range");
  end

  state_t        state, state_n;
  logic          cmd_ready_q, cmd_ready_n;
  logic          wen_q, wen_n, ren_q, ren_n;
  logic          wr_q, wr_n;
  logic [AW-1:0] addr_q, addr_n;
  logic [DW-1:0] wdata_q, wdata_n;
  logic          rsp_valid_q, rsp_valid_n;
  logic [DW-1:0] rdata_q, rdata_n;
  rsp_stat_t     stat_q, stat_n;
  logic          hs;
  logic          strobe;
  logic          expire;

  assign hs     = bus.cmd_valid_i && cmd_ready_q;
  assign strobe = wen_q || ren_q;

`ifdef SYS_MST_TIMEOUT_EN
  red_pitaya_sys_tmo #(.TMO(TMO)) u_tmo (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .load   (hs),
    .en     (state == WAIT),
    .expire (expire)
  );
`else
  assign expire = 1'b0;
`endif

  always_comb begin
    state_n     = state;
    cmd_ready_n = 1'b0;
    wen_n       = 1'b0;
    ren_n       = 1'b0;
    wr_n        = wr_q;
    addr_n      = addr_q;
    wdata_n     = wdata_q;
    rsp_valid_n = rsp_valid_q;
    rdata_n     = rdata_q;
    stat_n      = stat_q;
    unique case (state)
      IDLE: begin
        cmd_ready_n = 1'b1;
        if (hs) begin
          state_n     = WAIT;
          cmd_ready_n = 1'b0;
          wr_n        = bus.cmd_wr_i;
          addr_n      = bus.cmd_addr_i;
          wen_n       = bus.cmd_wr_i;
          ren_n       = !bus.cmd_wr_i;
          if (bus.cmd_wr_i) wdata_n = bus.cmd_wdata_i;
        end
      end
      WAIT: begin
        // an ack during our own strobe cycle belongs to an older transfer
        if (!strobe && bus.sys_ack_i) begin
          state_n     = RESP;
          rsp_valid_n = 1'b1;
          stat_n      = '{err: bus.sys_err_i, tmo: 1'b0};
          if (!wr_q && !bus.sys_err_i) rdata_n = bus.sys_rdata_i;
          else                         rdata_n = '0;
        end else if (expire) begin
          state_n     = RESP;
          rsp_valid_n = 1'b1;
          stat_n      = '{err: 1'b0, tmo: 1'b1};
          rdata_n     = '0;
        end
      end
      RESP: begin
        if (bus.rsp_ready_i) begin
          state_n     = IDLE;
          rsp_valid_n = 1'b0;
          rdata_n     = '0;
          stat_n      = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state       <= IDLE;
      cmd_ready_q <= 1'b0;
      wen_q       <= 1'b0;
      ren_q       <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      stat_q      <= '0;
    end else begin
      state       <= state_n;
      cmd_ready_q <= cmd_ready_n;
      wen_q       <= wen_n;
      ren_q       <= ren_n;
      wr_q        <= wr_n;
      addr_q      <= addr_n;
      wdata_q     <= wdata_n;
      rsp_valid_q <= rsp_valid_n;
      rdata_q     <= rdata_n;
      stat_q      <= stat_n;
    end
  end

  assign bus.cmd_ready_o = cmd_ready_q;
  assign bus.sys_addr_o  = addr_q;
  assign bus.sys_wdata_o = wdata_q;
  assign bus.sys_wen_o   = wen_q;
  assign bus.sys_ren_o   = ren_q;
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_rdata_o = rdata_q;
  assign bus.rsp_err_o   = stat_q.err;
  assign bus.rsp_tmo_o   = stat_q.tmo;
  assign bus.busy_o      = (state != IDLE);

endmodule

// File: tb/tb_red_pitaya_sys_master.sv
// Scoreboard bench for red_pitaya_sys_master with a directed bus responder.
// Timeout vectors change expectations when SYS_MST_TIMEOUT_EN is defined.
module tb_red_pitaya_sys_master;

  localparam int TMO = 8;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        tmo;
    int          lat;
  } exp_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  red_pitaya_sys_master_if #(.AW(32), .DW(32)) bus ();

  red_pitaya_sys_master #(.AW(32), .DW(32), .TMO(TMO)) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  exp_t        q[$];
  exp_t        cur;
  int          n_vec = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          strobe_cyc = 0;
  int          n_strobes = 0;
  int          rsp_delay = 1;
  logic        rsp_err = 1'b0;
  logic [31:0] rsp_data = '0;
  logic        pre_ack = 1'b0;
  logic        idle_ack_req = 1'b0;
  logic        exp_wr = 1'b0;
  logic [31:0] exp_addr = '0;
  logic [31:0] exp_wdata = '0;
  logic [31:0] strobe_addr = '0;
  logic        prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // responder: acks rsp_delay cycles after each strobe
  initial begin
    bus.sys_ack_i   = 1'b0;
    bus.sys_err_i   = 1'b0;
    bus.sys_rdata_i = '0;
    forever begin
      tick;
      bus.sys_ack_i   = idle_ack_req;
      bus.sys_err_i   = 1'b0;
      bus.sys_rdata_i = idle_ack_req ? 32'hDEAD_0000 : 32'h0;
      if (bus.sys_wen_o || bus.sys_ren_o) begin
        strobe_cyc  = cyc;
        strobe_addr = bus.sys_addr_o;
        n_strobes++;
        chk("strobe_kind", 32'(bus.sys_wen_o), 32'(exp_wr));
        chk("strobe_addr", bus.sys_addr_o, exp_addr);
        if (exp_wr) chk("strobe_wdata", bus.sys_wdata_o, exp_wdata);
        if (pre_ack) begin
          bus.sys_ack_i   = 1'b1;
          bus.sys_rdata_i = 32'hBAD0_BAD0;
        end
        for (int k = 1; k <= rsp_delay; k++) begin
          tick;
          bus.sys_ack_i   = 1'b0;
          bus.sys_err_i   = 1'b0;
          bus.sys_rdata_i = '0;
          if (rstn && bus.busy_o) begin
            chk("strobe_width", 32'(bus.sys_wen_o | bus.sys_ren_o), 32'h0);
            chk("addr_hold", bus.sys_addr_o, strobe_addr);
          end
          if (k == rsp_delay) begin
            bus.sys_ack_i   = 1'b1;
            bus.sys_err_i   = rsp_err;
            bus.sys_rdata_i = rsp_data;
          end
        end
      end
    end
  end

  // monitor: latency on rising rsp_valid, fields on handshake
  always @(negedge clk) begin
    if (rstn) begin
      if (bus.rsp_valid_o && !prev_valid) begin
        if (q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_rsp: got a response, expected none");
        end else if (q[0].lat >= 0) begin
          chk("latency", 32'(cyc - strobe_cyc), 32'(q[0].lat));
        end
      end
      if (bus.rsp_valid_o) begin
        chk("err_tmo_excl", 32'(bus.rsp_err_o & bus.rsp_tmo_o), 32'h0);
      end
      if (bus.rsp_valid_o && bus.rsp_ready_i && q.size() > 0) begin
        cur = q.pop_front();
        chk("rsp_rdata", bus.rsp_rdata_o, cur.rdata);
        chk("rsp_err", 32'(bus.rsp_err_o), 32'(cur.err));
        chk("rsp_tmo", 32'(bus.rsp_tmo_o), 32'(cur.tmo));
      end
    end
    prev_valid = bus.rsp_valid_o;
  end

  task automatic issue(input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic hold);
    int i;
    exp_wr          = wr;
    exp_addr        = addr;
    exp_wdata       = wdata;
    bus.cmd_wr_i    = wr;
    bus.cmd_addr_i  = addr;
    bus.cmd_wdata_i = wdata;
    bus.cmd_valid_i = 1'b1;
    for (i = 0; i < 50; i++) begin
      if (bus.cmd_ready_o) break;
      tick;
    end
    if (i == 50) begin
      n_vec++;
      n_bad++;
      $display("FAIL cmd_accept: got no cmd_ready, expected handshake");
    end else begin
      tick;
    end
    if (!hold) bus.cmd_valid_i = 1'b0;
  endtask

  task automatic wait_empty;
    for (int i = 0; i < 100 && q.size() != 0; i++) tick;
    if (q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL rsp_wait: got %0d pending, expected 0", q.size());
      q.delete();
    end
    repeat (3) tick;
  endtask

  task automatic xfer(input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input int delay,
                      input logic err, input logic [31:0] data,
                      input logic [31:0] e_rdata, input logic e_err,
                      input logic e_tmo, input int e_lat);
    exp_t e;
    rsp_delay = delay;
    rsp_err   = err;
    rsp_data  = data;
    e.rdata   = e_rdata;
    e.err     = e_err;
    e.tmo     = e_tmo;
    e.lat     = e_lat;
    q.push_back(e);
    issue(wr, addr, wdata, 1'b0);
    wait_empty();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int i;
    bus.cmd_valid_i = 1'b0;
    bus.cmd_wr_i    = 1'b0;
    bus.cmd_addr_i  = '0;
    bus.cmd_wdata_i = '0;
    bus.rsp_ready_i = 1'b1;
    repeat (2) tick;
    chk("rst_cmd_ready", 32'(bus.cmd_ready_o), 32'h0);
    chk("rst_busy", 32'(bus.busy_o), 32'h0);
    chk("rst_ren", 32'(bus.sys_ren_o | bus.sys_wen_o), 32'h0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid_o), 32'h0);
    rstn = 1'b1;
    chk("ready_before_edge", 32'(bus.cmd_ready_o), 32'h0);
    tick;
    chk("ready_after_edge", 32'(bus.cmd_ready_o), 32'h1);

    xfer(1'b1, 32'h30, 32'hA5, 1, 1'b0, 32'h1111, 32'h0, 1'b0, 1'b0, 2);
    xfer(1'b0, 32'h00, 32'h0, 4, 1'b0, 32'h1, 32'h1, 1'b0, 1'b0, 5);
    xfer(1'b0, 32'h04, 32'h0, 1, 1'b1, 32'h55, 32'h0, 1'b1, 1'b0, 2);
    pre_ack = 1'b1;
    xfer(1'b0, 32'h08, 32'h0, 2, 1'b0, 32'h1234, 32'h1234, 1'b0, 1'b0, 3);
    pre_ack = 1'b0;

    idle_ack_req = 1'b1;
    repeat (3) tick;
    idle_ack_req = 1'b0;
    repeat (2) tick;
    chk("idle_ack_rsp", 32'(bus.rsp_valid_o), 32'h0);
    chk("idle_ack_busy", 32'(bus.busy_o), 32'h0);

    bus.rsp_ready_i = 1'b0;
    rsp_delay = 1;
    rsp_err   = 1'b0;
    rsp_data  = 32'hCAFE;
    q.push_back('{rdata: 32'hCAFE, err: 1'b0, tmo: 1'b0, lat: 2});
    issue(1'b0, 32'h10, 32'h0, 1'b1);
    for (i = 0; i < 20 && !bus.rsp_valid_o; i++) tick;
    n0 = n_strobes;
    repeat (5) begin
      tick;
      chk("bp_valid", 32'(bus.rsp_valid_o), 32'h1);
      chk("bp_cmd_ready", 32'(bus.cmd_ready_o), 32'h0);
      chk("bp_rdata", bus.rsp_rdata_o, 32'hCAFE);
      chk("bp_err", 32'(bus.rsp_err_o), 32'h0);
      chk("bp_strobes", 32'(n_strobes), 32'(n0));
    end
    bus.cmd_valid_i = 1'b0;
    bus.rsp_ready_i = 1'b1;
    wait_empty();

`ifdef SYS_MST_TIMEOUT_EN
    xfer(1'b0, 32'h20, 32'h0, 10, 1'b0, 32'h777, 32'h0, 1'b0, 1'b1, TMO + 1);
`else
    xfer(1'b0, 32'h20, 32'h0, 10, 1'b0, 32'h777, 32'h777, 1'b0, 1'b0, 11);
`endif
    xfer(1'b0, 32'h24, 32'h0, 2, 1'b0, 32'h77, 32'h77, 1'b0, 1'b0, 3);

    rsp_delay = 20;
    rsp_data  = 32'hBEEF;
    issue(1'b0, 32'h40, 32'h0, 1'b0);
    repeat (3) tick;
    rstn = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(bus.busy_o), 32'h0);
    chk("mid_rst_addr", bus.sys_addr_o, 32'h0);
    chk("mid_rst_strobe", 32'(bus.sys_ren_o | bus.sys_wen_o), 32'h0);
    chk("mid_rst_rsp", 32'(bus.rsp_valid_o), 32'h0);
    chk("mid_rst_ready", 32'(bus.cmd_ready_o), 32'h0);
    repeat (2) tick;
    rstn = 1'b1;
    repeat (25) tick;
    chk("post_rst_rsp", 32'(bus.rsp_valid_o), 32'h0);
    xfer(1'b0, 32'h44, 32'h0, 1, 1'b0, 32'h99, 32'h99, 1'b0, 1'b0, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
